// File: rtl/inst_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit_if : imem request/response, decode and redirect bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface inst_fetch_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            dec_valid;
  logic            dec_ready;
  logic [31:0]     dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  // Fetch unit side
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output dec_valid,
    output dec_instr,
    output dec_pc,
    input  dec_ready,
    input  redirect_valid,
    input  redirect_pc
  );

  // Memory / decode / branch-unit side
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  dec_valid,
    input  dec_instr,
    input  dec_pc,
    output dec_ready,
    output redirect_valid,
    output redirect_pc
  );

endinterface

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit : in-order fetch front end with credit-limited prefetch queue
// Optional macro FETCH_PERF_CNT_EN adds the fetch_count port and counter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inst_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 4
) (
  input  wire               clk,
  input  wire               reset,
  inst_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  localparam int unsigned     PTR_W       = $clog2(QDEPTH);
  localparam int unsigned     CNT_W       = PTR_W + 1;
  localparam logic [XLEN-1:0] RESET_PC_AL = {RESET_PC[XLEN-1:2], 2'b00};
  localparam logic [CNT_W:0]  CREDIT_MAX  = (CNT_W + 1)'(QDEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] q_count_q, q_count_d;
  logic [PTR_W-1:0] q_rd_ptr_q, q_rd_ptr_d;
  logic [PTR_W-1:0] q_wr_ptr_q, q_wr_ptr_d;
  logic [PTR_W-1:0] pf_rd_ptr_q, pf_rd_ptr_d;
  logic [PTR_W-1:0] pf_wr_ptr_q, pf_wr_ptr_d;
  logic             dec_valid_q, dec_valid_d;
  logic [31:0]      dec_instr_q, dec_instr_d;
  logic [XLEN-1:0]  dec_pc_q, dec_pc_d;

  // Prefetch queue payload, plus PCs of requests still waiting for data
  logic [31:0]      q_instr_mem [QDEPTH];
  logic [XLEN-1:0]  q_pc_mem    [QDEPTH];
  logic [XLEN-1:0]  pf_pc_mem   [QDEPTH];

  logic             credit_ok;
  logic             req_valid;
  logic             accept;
  logic             rsp;
  logic             rsp_drop;
  logic             redirect;
  logic             push;
  logic             pop;
  logic [XLEN-1:0]  rsp_pc;
  logic [PTR_W-1:0] q_next_ptr;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  always_comb begin
    credit_ok  = ({1'b0, inflight_q} + {1'b0, q_count_q}) < CREDIT_MAX;
    redirect   = bus.redirect_valid && (state_q != ST_IDLE);
    req_valid  = (state_q == ST_RUN) && !bus.redirect_valid && credit_ok;
    accept     = req_valid && bus.imem_req_ready;
    rsp        = bus.imem_rsp_valid;
    rsp_drop   = rsp && (drop_q != '0);
    push       = rsp && !rsp_drop && !redirect;
    pop        = dec_valid_q && bus.dec_ready;
    rsp_pc     = pf_pc_mem[pf_rd_ptr_q];
    q_next_ptr = q_rd_ptr_q + PTR_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    inflight_d  = inflight_q + CNT_W'(accept) - CNT_W'(rsp);
    drop_d      = rsp_drop ? (drop_q - CNT_W'(1)) : drop_q;
    pf_wr_ptr_d = accept ? (pf_wr_ptr_q + PTR_W'(1)) : pf_wr_ptr_q;
    pf_rd_ptr_d = rsp ? (pf_rd_ptr_q + PTR_W'(1)) : pf_rd_ptr_q;
    q_wr_ptr_d  = push ? (q_wr_ptr_q + PTR_W'(1)) : q_wr_ptr_q;
    q_rd_ptr_d  = pop ? (q_rd_ptr_q + PTR_W'(1)) : q_rd_ptr_q;
    q_count_d   = q_count_q + CNT_W'(push) - CNT_W'(pop);
    dec_valid_d = dec_valid_q;
    dec_instr_d = dec_instr_q;
    dec_pc_d    = dec_pc_q;

    if (accept) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end

    // The decode registers mirror the queue head; refill them when the head
    // leaves or when the first word lands in an empty queue.
    if (pop) begin
      if (q_count_q > CNT_W'(1)) begin
        dec_valid_d = 1'b1;
        dec_instr_d = q_instr_mem[q_next_ptr];
        dec_pc_d    = q_pc_mem[q_next_ptr];
      end else if (push) begin
        dec_valid_d = 1'b1;
        dec_instr_d = bus.imem_rsp_data;
        dec_pc_d    = rsp_pc;
      end else begin
        dec_valid_d = 1'b0;
      end
    end else if (push && (q_count_q == '0)) begin
      dec_valid_d = 1'b1;
      dec_instr_d = bus.imem_rsp_data;
      dec_pc_d    = rsp_pc;
    end

    // Everything still outstanding after this edge belongs to the old path.
    if (redirect) begin
      drop_d      = inflight_d;
      fetch_pc_d  = {bus.redirect_pc[XLEN-1:2], 2'b00};
      q_count_d   = '0;
      q_rd_ptr_d  = '0;
      q_wr_ptr_d  = '0;
      dec_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE:  state_d = ST_RUN;
      ST_RUN:   if (redirect && (inflight_d != '0)) state_d = ST_FLUSH;
      ST_FLUSH: if (drop_d == '0) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC_AL;
      inflight_q  <= '0;
      drop_q      <= '0;
      q_count_q   <= '0;
      q_rd_ptr_q  <= '0;
      q_wr_ptr_q  <= '0;
      pf_rd_ptr_q <= '0;
      pf_wr_ptr_q <= '0;
      dec_valid_q <= 1'b0;
      dec_instr_q <= '0;
      dec_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      q_count_q   <= q_count_d;
      q_rd_ptr_q  <= q_rd_ptr_d;
      q_wr_ptr_q  <= q_wr_ptr_d;
      pf_rd_ptr_q <= pf_rd_ptr_d;
      pf_wr_ptr_q <= pf_wr_ptr_d;
      dec_valid_q <= dec_valid_d;
      dec_instr_q <= dec_instr_d;
      dec_pc_q    <= dec_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr_mem[q_wr_ptr_q] <= bus.imem_rsp_data;
      q_pc_mem[q_wr_ptr_q]    <= rsp_pc;
    end
    if (accept) begin
      pf_pc_mem[pf_wr_ptr_q] <= fetch_pc_q;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.dec_valid      = dec_valid_q;
  assign bus.dec_instr      = dec_instr_q;
  assign bus.dec_pc         = dec_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = pop ? (fetch_count_q + 32'd1) : fetch_count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit : scoreboard bench for inst_fetch_unit with an imem model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch_unit;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_unit_if #(.XLEN(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  inst_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          n_cmp     = 0;
  int          n_bad     = 0;
  int          cyc       = 0;
  int          lat       = 1;
  int          acc_count = 0;
  int          hs_count  = 0;
  logic [31:0] exp_addr  = 32'h0;
  logic [31:0] exp_pc_q[$];
  pend_t       pend_q[$];
  pend_t       mon_e;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    while (exp_pc_q.size() > 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    n_cmp++;
    if (exp_pc_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d decode entries still pending after %0d cycles, expected 0",
               name, exp_pc_q.size(), bound);
      exp_pc_q.delete();
    end
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    exp_addr           = pc & 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic push_pcs(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_pc_q.push_back(base + 32'(4 * i));
  endtask

  always @(posedge clk) cyc++;

  // imem model and decode-ready driver
  always @(posedge clk) begin
    #1;
    bus.imem_rsp_valid = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = instr_of(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
    bus.dec_ready = (exp_pc_q.size() > 0);
  end

  // Monitor: checks each accepted request and each decode handshake
  always @(negedge clk) begin
    if (reset) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        check("imem_req_addr", bus.imem_req_addr, exp_addr);
        mon_e.addr = bus.imem_req_addr;
        mon_e.due  = cyc + lat;
        pend_q.push_back(mon_e);
        exp_addr  = exp_addr + 32'd4;
        acc_count++;
      end
      if (bus.dec_valid && bus.dec_ready) begin
        hs_count++;
        if (exp_pc_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_dec: got pc %h, expected no handshake", bus.dec_pc);
        end else begin
          logic [31:0] p;
          p = exp_pc_q.pop_front();
          check("dec_pc", bus.dec_pc, p);
          check("dec_instr", bus.dec_instr, instr_of(p));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int n;
    bit found;

    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.dec_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_req_addr",  bus.imem_req_addr, 32'h0);
    check("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    check("rst_dec_instr", bus.dec_instr, 32'h0);
    check("rst_dec_pc",    bus.dec_pc, 32'h0);
    step();
    reset = 1'b1;

    // Streaming fetch from address 0
    push_pcs(32'h0, 16);
    wait_drain("stream", 200);

    // Decode stalled: only QDEPTH more accepts, then requests stop
    repeat (10) step();
    @(negedge clk);
    check("stall_accepts",   32'(acc_count), 32'd20);
    check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("stall_dec_valid", 32'(bus.dec_valid), 32'd1);
    check("stall_head_pc",   bus.dec_pc, 32'h40);
    push_pcs(32'h40, 8);
    wait_drain("resume", 200);
    repeat (10) step();

    // Three requests in flight, then redirect to an unaligned target
    step();
    bus.imem_req_ready = 1'b0;
    redirect_to(32'h200);
    lat  = 8;
    base = acc_count;
    bus.imem_req_ready = 1'b1;
    n = 0;
    while (acc_count < base + 3 && n < 50) begin
      step();
      n++;
    end
    bus.imem_req_ready = 1'b0;
    check("inflight_accepts", 32'(acc_count - base), 32'd3);
    redirect_to(32'h103);
    lat = 1;
    bus.imem_req_ready = 1'b1;
    push_pcs(32'h100, 8);
    wait_drain("after_flush", 200);
    repeat (10) step();

    // Redirect in the same cycle as a decode pop and an imem response
    step();
    push_pcs(32'h120, 3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #4;
      if (bus.imem_rsp_valid && bus.dec_ready && bus.dec_valid) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        exp_addr           = 32'h300;
        found              = 1'b1;
      end
    end
    check("coincident_found", 32'(found), 32'd1);
    step();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_queue_empty", 32'(bus.dec_valid), 32'd0);
    check("redir_pop_taken",   32'(exp_pc_q.size()), 32'd0);
    exp_pc_q.delete();
    push_pcs(32'h300, 4);
    wait_drain("after_coincident", 200);

    // Address wrap at the top of the address space
    redirect_to(32'hFFFF_FFF8);
    exp_pc_q.push_back(32'hFFFF_FFF8);
    exp_pc_q.push_back(32'hFFFF_FFFC);
    exp_pc_q.push_back(32'h0000_0000);
    exp_pc_q.push_back(32'h0000_0004);
    wait_drain("wrap", 200);

`ifdef FETCH_PERF_CNT_EN
    @(negedge clk);
    check("fetch_count", fetch_count, 32'(hs_count));
`endif

    // Reset mid-operation
    step();
    reset = 1'b0;
    pend_q.delete();
    exp_pc_q.delete();
    @(negedge clk);
    check("mid_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("mid_rst_req_addr",  bus.imem_req_addr, 32'h0);
    check("mid_rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    check("mid_rst_dec_instr", bus.dec_instr, 32'h0);
    check("mid_rst_dec_pc",    bus.dec_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("mid_rst_fetch_count", fetch_count, 32'h0);
`endif
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
